// File: rtl/uart_rx_fifo_ctrl_if.sv
// Signal bundle between the RX FIFO sequencer and its neighbours (RX shifter, FIFO storage, CPU regs).
// The slave side is the sequencer; the master side is everything around it.
interface uart_rx_fifo_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 32,
   parameter int CNT_W  = $clog2(DEPTH) + 1
);
   logic              rx_done_i;
   logic              fifo_wr_o;
   logic              fifo_rd_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              cpu_rd_req_i;
   logic [DATA_W-1:0] cpu_rdata_o;
   logic              cpu_rvalid_o;
   logic              rd_empty_o;
   logic [CNT_W-1:0]  thresh_i;
   logic              ovr_clr_i;
   logic [CNT_W-1:0]  fifo_cnt_o;
   logic              overrun_o;
   logic              timeout_o;
   logic              irq_o;

   modport master (
      output rx_done_i, mem_rdata_i, cpu_rd_req_i, thresh_i, ovr_clr_i,
      input  fifo_wr_o, fifo_rd_o, cpu_rdata_o, cpu_rvalid_o, rd_empty_o,
             fifo_cnt_o, overrun_o, timeout_o, irq_o
   );

   modport slave (
      input  rx_done_i, mem_rdata_i, cpu_rd_req_i, thresh_i, ovr_clr_i,
      output fifo_wr_o, fifo_rd_o, cpu_rdata_o, cpu_rvalid_o, rd_empty_o,
             fifo_cnt_o, overrun_o, timeout_o, irq_o
   );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// UART RX FIFO sequencer: byte-done pulses become FIFO writes, CPU reads become a
// three-state fetch with registered data return; owns fill count, overrun, timeout and IRQ.
module uart_rx_fifo_ctrl #(
   parameter  int DATA_W  = 8,
   parameter  int DEPTH   = 32,
   parameter  int TMO_CYC = 640,
   localparam int CNT_W   = $clog2(DEPTH) + 1,
   localparam int TMO_W   = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1
) (
   input logic             clk,
   input logic             rst,
   uart_rx_fifo_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FETCH, RET} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [DATA_W-1:0] rdata;
   logic              rvalid, rd_empty, overrun, timeout, irq;
   logic              full, empty, wr, rd, thr_hit;

   // Strobes are combinational so storage moves in the same cycle as the event.
   assign full    = (cnt == CNT_W'(DEPTH));
   assign empty   = (cnt == '0);
   assign wr      = bus.rx_done_i & ~full;
   assign rd      = (state == IDLE) & bus.cpu_rd_req_i & ~empty;
   assign thr_hit = (bus.thresh_i != '0) && (cnt >= bus.thresh_i);

   assign bus.fifo_wr_o    = wr;
   assign bus.fifo_rd_o    = rd;
   assign bus.fifo_cnt_o   = cnt;
   assign bus.cpu_rdata_o  = rdata;
   assign bus.cpu_rvalid_o = rvalid;
   assign bus.rd_empty_o   = rd_empty;
   assign bus.overrun_o    = overrun;
   assign bus.timeout_o    = timeout;
   assign bus.irq_o        = irq;

   // Requests arriving in FETCH/RET are dropped, not queued.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rdata    <= '0;
         rvalid   <= 1'b0;
         rd_empty <= 1'b0;
      end else begin
         rvalid   <= 1'b0;
         rd_empty <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cpu_rd_req_i) begin
                  if (!empty) state    <= FETCH;
                  else        rd_empty <= 1'b1;
               end
            end
            FETCH: begin
               rdata  <= bus.mem_rdata_i;
               rvalid <= 1'b1;
               state  <= RET;
            end
            RET:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         case ({wr, rd})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                        overrun <= 1'b0;
      else if (bus.ovr_clr_i)         overrun <= 1'b0;
      else if (bus.rx_done_i && full) overrun <= 1'b1;
   end

   // Timer saturates at TMO_CYC-1 so the flag stays up until the FIFO is touched.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt <= '0;
         timeout <= 1'b0;
      end else if (wr || rd || empty) begin
         tmo_cnt <= '0;
         timeout <= 1'b0;
      end else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
         timeout <= 1'b1;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) irq <= 1'b0;
      else     irq <= overrun | timeout | thr_hit;
   end

   a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt <= CNT_W'(DEPTH));
   a_rvalid_ret: assert property (@(posedge clk) disable iff (rst) rvalid |-> state == RET);

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Bench for uart_rx_fifo_ctrl: vector table plus hand sequences, storage model and return scoreboard.
module tb_uart_rx_fifo_ctrl;
   localparam int DW = 8, DEPTH = 32, CW = 6, TMO = 40;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_rx_fifo_ctrl_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus();
   uart_rx_fifo_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .TMO_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   typedef struct {
      logic          rx;
      logic [DW-1:0] b;
      logic          req;
      logic [CW-1:0] thr;
      logic          e_wr;
      logic          e_rd;
      logic [CW-1:0] e_cnt;
      logic          e_irq;
   } vec_t;

   logic [DW-1:0] rx_byte;
   logic [DW-1:0] mem_q[$], data_model[$], exp_q[$];
   int n_chk = 0, n_fail = 0;
   vec_t vt[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One stimulus cycle; expected strobes checked, models updated, then inputs released.
   task automatic drive(input logic rx, input logic [DW-1:0] b, input logic req, input logic clr,
                        input logic e_wr, input logic e_rd, input string nm);
      bus.rx_done_i = rx; rx_byte = b; bus.cpu_rd_req_i = req; bus.ovr_clr_i = clr;
      #1;
      chk({nm, ".fifo_wr"}, bus.fifo_wr_o, e_wr);
      chk({nm, ".fifo_rd"}, bus.fifo_rd_o, e_rd);
      if (e_rd && data_model.size() != 0) exp_q.push_back(data_model.pop_front());
      if (e_wr) data_model.push_back(b);
      tick();
      bus.rx_done_i = 1'b0; bus.cpu_rd_req_i = 1'b0; bus.ovr_clr_i = 1'b0;
   endtask

   // FIFO storage: data appears one cycle after the read strobe.
   always @(posedge clk) begin
      if (rst) mem_q.delete();
      else begin
         if (bus.fifo_wr_o) mem_q.push_back(rx_byte);
         if (bus.fifo_rd_o && mem_q.size() != 0) bus.mem_rdata_i <= mem_q.pop_front();
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b0 && bus.cpu_rvalid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_rvalid: got rvalid with data %0h, required no return", bus.cpu_rdata_o);
         end else chk("rdata", bus.cpu_rdata_o, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           rx    b      req   thr   wr    rd    cnt   irq
      vt[0] = '{1'b0, 8'h00, 1'b1, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0};
      vt[1] = '{1'b1, 8'hA5, 1'b0, 6'd0, 1'b1, 1'b0, 6'd1, 1'b0};
      vt[2] = '{1'b1, 8'h3C, 1'b0, 6'd0, 1'b1, 1'b0, 6'd2, 1'b0};
      vt[3] = '{1'b1, 8'h7E, 1'b0, 6'd3, 1'b1, 1'b0, 6'd3, 1'b1};
      vt[4] = '{1'b0, 8'h00, 1'b1, 6'd3, 1'b0, 1'b1, 6'd2, 1'b0};
      vt[5] = '{1'b1, 8'h11, 1'b1, 6'd2, 1'b1, 1'b1, 6'd2, 1'b1};
      vt[6] = '{1'b0, 8'h00, 1'b1, 6'd2, 1'b0, 1'b1, 6'd1, 1'b0};
      vt[7] = '{1'b0, 8'h00, 1'b1, 6'd1, 1'b0, 1'b1, 6'd0, 1'b0};
      vt[8] = '{1'b1, 8'h99, 1'b0, 6'd1, 1'b1, 1'b0, 6'd1, 1'b1};
      vt[9] = '{1'b0, 8'h00, 1'b1, 6'd0, 1'b0, 1'b1, 6'd0, 1'b0};

      rst = 1'b1; rx_byte = '0;
      bus.rx_done_i = 1'b0; bus.cpu_rd_req_i = 1'b0; bus.thresh_i = '0; bus.ovr_clr_i = 1'b0;
      tick(); tick(); tick();
      chk("rst.cnt", bus.fifo_cnt_o, 0);
      chk("rst.rdata", bus.cpu_rdata_o, 0);
      chk("rst.rvalid", bus.cpu_rvalid_o, 0);
      chk("rst.rd_empty", bus.rd_empty_o, 0);
      chk("rst.overrun", bus.overrun_o, 0);
      chk("rst.timeout", bus.timeout_o, 0);
      chk("rst.irq", bus.irq_o, 0);
      chk("rst.fifo_wr", bus.fifo_wr_o, 0);
      chk("rst.fifo_rd", bus.fifo_rd_o, 0);
      rst = 1'b0;
      tick();

      // Table: one op per vector, then settle until the FSM is idle again.
      for (int i = 0; i < 10; i++) begin
         bus.thresh_i = vt[i].thr;
         drive(vt[i].rx, vt[i].b, vt[i].req, 1'b0, vt[i].e_wr, vt[i].e_rd, $sformatf("vec%0d", i));
         tick();
         chk($sformatf("vec%0d.cnt", i), bus.fifo_cnt_o, vt[i].e_cnt);
         chk($sformatf("vec%0d.irq", i), bus.irq_o, vt[i].e_irq);
         tick();
      end
      bus.thresh_i = '0;

      // T1: reset during FETCH aborts the return.
      drive(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, "t1w0");
      drive(1'b1, 8'h4D, 1'b0, 1'b0, 1'b1, 1'b0, "t1w1");
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "t1rd");
      rst = 1'b1; exp_q.delete(); data_model.delete();
      tick(); tick();
      rst = 1'b0;
      chk("t1.cnt", bus.fifo_cnt_o, 0);
      chk("t1.rdata", bus.cpu_rdata_o, 0);
      chk("t1.rvalid", bus.cpu_rvalid_o, 0);
      chk("t1.overrun", bus.overrun_o, 0);
      chk("t1.irq", bus.irq_o, 0);
      repeat (4) tick();

      // T2: exact read latency.
      drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, "t2w");
      repeat (4) tick();
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "t2rd");
      chk("t2.c6_rvalid", bus.cpu_rvalid_o, 0);
      chk("t2.cnt", bus.fifo_cnt_o, 0);
      tick();
      chk("t2.c7_rvalid", bus.cpu_rvalid_o, 1);
      chk("t2.c7_rdata", bus.cpu_rdata_o, 8'h5A);
      tick();
      chk("t2.c8_rvalid", bus.cpu_rvalid_o, 0);

      // Held request: ignored in FETCH/RET, accepted again three cycles later.
      drive(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0, "hw0");
      drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, "hw1");
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "hold0");
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "hold1");
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "hold2");
      chk("hold.rd_empty", bus.rd_empty_o, 0);
      chk("hold.cnt", bus.fifo_cnt_o, 1);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "hold3");
      tick(); tick();
      chk("hold.cnt_end", bus.fifo_cnt_o, 0);

      // T3: fill to DEPTH, overflow, clear.
      for (int i = 0; i < 33; i++) begin
         drive(1'b1, DW'(i) ^ 8'hA0, 1'b0, 1'b0, (i < 32), 1'b0, $sformatf("fill%0d", i));
         if (i == 31) chk("t3.ovr_before", bus.overrun_o, 0);
      end
      chk("t3.cnt", bus.fifo_cnt_o, 32);
      chk("t3.overrun", bus.overrun_o, 1);
      tick();
      chk("t3.irq", bus.irq_o, 1);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "t3clr");
      chk("t3.ovr_clr", bus.overrun_o, 0);

      // T4: full with simultaneous rx_done and read.
      drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b1, "t4");
      chk("t4.cnt", bus.fifo_cnt_o, 31);
      chk("t4.overrun", bus.overrun_o, 1);
      tick(); tick();
      drive(1'b1, 8'hF1, 1'b0, 1'b0, 1'b1, 1'b0, "t4w");
      drive(1'b1, 8'hF2, 1'b0, 1'b1, 1'b0, 1'b0, "clr_win");
      chk("clr_win.overrun", bus.overrun_o, 0);
      chk("clr_win.cnt", bus.fifo_cnt_o, 32);
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, $sformatf("drain%0d", i));
         tick(); tick();
      end
      chk("drain.cnt", bus.fifo_cnt_o, 0);

      // T5: read when empty.
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "t5");
      chk("t5.rd_empty", bus.rd_empty_o, 1);
      tick();
      chk("t5.rd_empty_pulse", bus.rd_empty_o, 0);
      tick(); tick();

      // T6: threshold then character timeout.
      bus.thresh_i = 6'd4;
      for (int i = 0; i < 4; i++) drive(1'b1, 8'h30 + DW'(i), 1'b0, 1'b0, 1'b1, 1'b0, $sformatf("t6w%0d", i));
      chk("t6.cnt", bus.fifo_cnt_o, 4);
      chk("t6.irq_lag", bus.irq_o, 0);
      tick();
      chk("t6.irq_thr", bus.irq_o, 1);
      bus.thresh_i = '0;
      tick();
      chk("t6.irq_off", bus.irq_o, 0);
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, $sformatf("t6r%0d", i));
         tick(); tick();
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "t6r2");
      repeat (TMO - 1) tick();
      chk("t6.tmo_early", bus.timeout_o, 0);
      tick();
      chk("t6.tmo_fire", bus.timeout_o, 1);
      chk("t6.irq_tmo_lag", bus.irq_o, 0);
      tick();
      chk("t6.tmo_hold", bus.timeout_o, 1);
      chk("t6.irq_tmo", bus.irq_o, 1);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "t6r3");
      chk("t6.tmo_clr", bus.timeout_o, 0);
      chk("t6.cnt_end", bus.fifo_cnt_o, 0);
      tick(); tick();
      chk("t6.irq_clr", bus.irq_o, 0);

      repeat (3) tick();
      chk("sb_drain", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
